// File: rtl/iq_capture_deadlock_reporter.sv
// Debounces the dataflow monitor's block indication into confirmed deadlock events,
// raising a one-cycle interrupt and keeping sticky diagnostics until software clears them.
module iq_capture_deadlock_reporter #(
    parameter int CONFIRM_CYCLES = 16,
    parameter int AXIS_W         = 1,
    parameter int TS_WIDTH       = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 block_in,
    input  logic [AXIS_W-1:0]    axis_block_info_in,
    input  logic                 clear,
    output logic                 deadlock_irq,
    output logic                 deadlock_sticky,
    output logic [AXIS_W-1:0]    axis_info_latched,
    output logic [TS_WIDTH-1:0]  first_ts,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic [TS_WIDTH-1:0]  timestamp,
    output logic [1:0]           fsm_state
);

    localparam int RUN_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PENDING   = 2'd1,
        CONFIRMED = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] next_run_cnt;
    logic             enter_confirm;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= next_state;
            run_cnt <= next_run_cnt;
        end
    end

    // run_cnt holds the number of consecutive high samples already seen while PENDING
    always_comb begin
        next_state   = state;
        next_run_cnt = run_cnt;
        case (state)
            IDLE: begin
                if (block_in) begin
                    if (CONFIRM_CYCLES == 1) begin
                        next_state   = CONFIRMED;
                        next_run_cnt = '0;
                    end else begin
                        next_state   = PENDING;
                        next_run_cnt = RUN_ONE;
                    end
                end
            end
            PENDING: begin
                if (!block_in) begin
                    next_state   = IDLE;
                    next_run_cnt = '0;
                end else if (run_cnt == RUN_LAST) begin
                    next_state   = CONFIRMED;
                    next_run_cnt = '0;
                end else begin
                    next_run_cnt = run_cnt + RUN_ONE;
                end
            end
            CONFIRMED: begin
                next_state   = block_in ? HOLD : IDLE;
                next_run_cnt = '0;
            end
            HOLD: begin
                if (!block_in) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state   = IDLE;
                next_run_cnt = '0;
            end
        endcase
    end

    assign enter_confirm = (next_state == CONFIRMED);
    assign fsm_state     = state;

    // A confirmation on the same edge as clear wins: it restarts the diagnostics from this event
    always_ff @(posedge clock) begin
        if (reset) begin
            timestamp         <= '0;
            deadlock_irq      <= 1'b0;
            deadlock_sticky   <= 1'b0;
            axis_info_latched <= '0;
            first_ts          <= '0;
            event_count       <= '0;
        end else begin
            timestamp    <= timestamp + TS_WIDTH'(1);
            deadlock_irq <= enter_confirm;
            if (enter_confirm) begin
                deadlock_sticky <= 1'b1;
                if (clear) begin
                    event_count <= CNT_ONE;
                end else if (event_count != CNT_MAX) begin
                    event_count <= event_count + CNT_ONE;
                end
                if (!deadlock_sticky || clear) begin
                    first_ts          <= timestamp;
                    axis_info_latched <= axis_block_info_in;
                end
            end else if (clear) begin
                deadlock_sticky   <= 1'b0;
                axis_info_latched <= '0;
                first_ts          <= '0;
                event_count       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iq_capture_deadlock_reporter.sv
// Directed bench for iq_capture_deadlock_reporter with CONFIRM_CYCLES=4 and a 2-bit
// saturating event counter, using hand-computed timestamps and counts.
module tb_iq_capture_deadlock_reporter;

    localparam int CC = 4;
    localparam int AW = 2;
    localparam int TW = 32;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          block_in;
    logic [AW-1:0] axis_block_info_in;
    logic          clear;
    logic          deadlock_irq;
    logic          deadlock_sticky;
    logic [AW-1:0] axis_info_latched;
    logic [TW-1:0] first_ts;
    logic [CW-1:0] event_count;
    logic [TW-1:0] timestamp;
    logic [1:0]    fsm_state;

    int compared   = 0;
    int mismatched = 0;

    iq_capture_deadlock_reporter #(
        .CONFIRM_CYCLES(CC),
        .AXIS_W        (AW),
        .TS_WIDTH      (TW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .block_in          (block_in),
        .axis_block_info_in(axis_block_info_in),
        .clear             (clear),
        .deadlock_irq      (deadlock_irq),
        .deadlock_sticky   (deadlock_sticky),
        .axis_info_latched (axis_info_latched),
        .first_ts          (first_ts),
        .event_count       (event_count),
        .timestamp         (timestamp),
        .fsm_state         (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the sampling edge
    task automatic applyStimulus(input logic b, input logic [AW-1:0] a, input logic c);
        block_in           = b;
        axis_block_info_in = a;
        clear              = c;
        @(posedge clock);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_irq"},    deadlock_irq,      0);
        checkOutput({tag, "_sticky"}, deadlock_sticky,   0);
        checkOutput({tag, "_axis"},   axis_info_latched, 0);
        checkOutput({tag, "_fts"},    first_ts,          0);
        checkOutput({tag, "_cnt"},    event_count,       0);
        checkOutput({tag, "_ts"},     timestamp,         0);
        checkOutput({tag, "_state"},  fsm_state,         0);
    endtask

    // Holds block_in high for len cycles then drops it for one, checking state and irq each cycle
    task automatic runBurst(input string tag, input int len, input logic [AW-1:0] a);
        for (int k = 1; k <= len; k++) begin
            applyStimulus(1'b1, a, 1'b0);
            checkOutput({tag, "_state"}, fsm_state, (k < CC) ? 1 : (k == CC) ? 2 : 3);
            checkOutput({tag, "_irq"}, deadlock_irq, (k == CC) ? 1 : 0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput({tag, "_drop_state"}, fsm_state, 0);
        checkOutput({tag, "_drop_irq"}, deadlock_irq, 0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkAllZero("reset");
        reset = 1'b0;

        // Short run never confirms; timestamp ends at 4
        runBurst("short", 3, 2'b00);
        checkOutput("short_cnt", event_count, 0);
        checkOutput("short_sticky", deadlock_sticky, 0);
        checkOutput("short_ts", timestamp, 4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ts_10", timestamp, 10);

        // First confirm: edge sampled at ts=13, irq visible while ts reads 14
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            checkOutput("long_irq", deadlock_irq, (k == 4) ? 1 : 0);
            checkOutput("long_state", fsm_state, (k < 4) ? 1 : (k == 4) ? 2 : 3);
            if (k == 4) checkOutput("long_ts_at_irq", timestamp, 14);
        end
        checkOutput("long_fts", first_ts, 13);
        checkOutput("long_sticky", deadlock_sticky, 1);
        checkOutput("long_cnt", event_count, 1);
        checkOutput("long_axis", axis_info_latched, 0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("long_drop_state", fsm_state, 0);

        // Second burst counts but keeps first-event data
        runBurst("second", 6, 2'b11);
        checkOutput("second_cnt", event_count, 2);
        checkOutput("second_fts", first_ts, 13);
        checkOutput("second_axis", axis_info_latched, 0);

        // Clear on the confirming edge (ts=31): confirmation wins
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1);
        checkOutput("clrconf_state", fsm_state, 2);
        checkOutput("clrconf_irq", deadlock_irq, 1);
        checkOutput("clrconf_sticky", deadlock_sticky, 1);
        checkOutput("clrconf_cnt", event_count, 1);
        checkOutput("clrconf_fts", first_ts, 31);
        checkOutput("clrconf_axis", axis_info_latched, 2'b10);
        applyStimulus(1'b0, '0, 1'b0);

        // Plain clear wipes diagnostics (ts reads 34 afterwards)
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("clr_sticky", deadlock_sticky, 0);
        checkOutput("clr_cnt", event_count, 0);
        checkOutput("clr_fts", first_ts, 0);
        checkOutput("clr_axis", axis_info_latched, 0);
        checkOutput("clr_ts", timestamp, 34);

        // Five bursts: 2-bit counter saturates at 3, first event at ts=37
        for (int b = 1; b <= 5; b++) begin
            runBurst("sat", 4, (b == 1) ? 2'b01 : 2'b10);
            checkOutput("sat_cnt", event_count, (b < 3) ? b : 3);
            checkOutput("sat_fts", first_ts, 37);
            checkOutput("sat_axis", axis_info_latched, 2'b01);
        end

        // Reset while PENDING with run_cnt=2 discards everything
        applyStimulus(1'b1, '0, 1'b0);
        applyStimulus(1'b1, '0, 1'b0);
        checkOutput("prerst_state", fsm_state, 1);
        reset = 1'b1;
        applyStimulus(1'b1, '0, 1'b0);
        checkAllZero("midrst");
        applyStimulus(1'b1, '0, 1'b0);
        checkAllZero("midrst2");
        reset = 1'b0;
        runBurst("postrst", 4, 2'b01);
        checkOutput("postrst_fts", first_ts, 3);
        checkOutput("postrst_cnt", event_count, 1);
        checkOutput("postrst_axis", axis_info_latched, 2'b01);

        // Clear mid-run does not restart it; confirm lands at ts=9
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, '0, 1'b0);
        applyStimulus(1'b1, '0, 1'b1);
        checkOutput("clrpend_state", fsm_state, 1);
        applyStimulus(1'b1, '0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("clrpend_irq", deadlock_irq, 1);
        checkOutput("clrpend_cnt", event_count, 1);
        checkOutput("clrpend_fts", first_ts, 9);
        checkOutput("clrpend_axis", axis_info_latched, 2'b11);

        // Clear in HOLD: no re-confirmation while block_in stays high
        applyStimulus(1'b1, '0, 1'b1);
        checkOutput("clrhold_state", fsm_state, 3);
        checkOutput("clrhold_sticky", deadlock_sticky, 0);
        applyStimulus(1'b1, '0, 1'b0);
        checkOutput("hold_irq", deadlock_irq, 0);
        checkOutput("hold_cnt", event_count, 0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("hold_drop_state", fsm_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
